// File: rtl/bist_ora_misr.sv
// Output response analyser for the full-adder BIST loop: MISR compression of CUT responses,
// golden-signature compare on tpg_complete. Optional COMPRESS watchdog: define BIST_ORA_TIMEOUT_EN.
module bist_ora_misr #(
  parameter int                RESP_W      = 2,
  parameter int                SIG_W       = 4,
  parameter logic [SIG_W-1:0]  POLY        = 4'h3,
  parameter logic [SIG_W-1:0]  SEED        = 4'h0,
  parameter logic [SIG_W-1:0]  GOLDEN_SIG  = 4'hA,
  parameter int                CNT_W       = 8,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [RESP_W-1:0] resp_in,
  input  logic              resp_valid,
  input  logic              tpg_complete,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  vec_cnt,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout
);

  if (SIG_W < RESP_W || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("bist_ora_misr: need SIG_W >= RESP_W and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPRESS,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;

  // One MISR shift: feedback taps applied when the outgoing MSB is set, response folded into the LSBs.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [RESP_W-1:0] r);
    logic [SIG_W-1:0] nxt;
    nxt = {s[SIG_W-2:0], 1'b0};
    if (s[SIG_W-1]) nxt = nxt ^ POLY;
    return nxt ^ SIG_W'(r);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

`ifdef BIST_ORA_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
`ifdef BIST_ORA_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_COMPRESS;
          sig_d   = SEED;
          cnt_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
`ifdef BIST_ORA_TIMEOUT_EN
          tmo_cnt_d = '0;
          timeout_d = 1'b0;
`endif
        end
      end
      S_COMPRESS: begin
        if (resp_valid) begin
          sig_d = misr_step(sig_q, resp_in);
          cnt_d = sat_inc(cnt_q);
        end
`ifdef BIST_ORA_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        // tpg_complete takes priority over an expiring watchdog in the same cycle.
        if (tpg_complete) begin
          state_d = S_COMPARE;
        end
`ifdef BIST_ORA_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          fail_d    = 1'b1;
          timeout_d = 1'b1;
        end
`endif
      end
      S_COMPARE: begin
        pass_d  = (sig_q == GOLDEN_SIG);
        fail_d  = (sig_q != GOLDEN_SIG);
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

`ifdef BIST_ORA_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign signature = sig_q;
  assign vec_cnt   = cnt_q;
  assign busy      = (state_q == S_COMPRESS) || (state_q == S_COMPARE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_bist_ora_misr.sv
// Bench for bist_ora_misr: vector table, hand-written corner sequences and randomized
// analyses checked against a signature model computed with plain arithmetic.
module tb_bist_ora_misr;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] resp_in = 2'b00;
  logic       resp_valid = 1'b0;
  logic       tpg_complete = 1'b0;
  logic [3:0] signature;
  logic [7:0] vec_cnt;
  logic       busy, done, pass, fail, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [3:0] GOLD = 4'hA;

  always #5 clock = ~clock;

  bist_ora_misr dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .resp_in      (resp_in),
    .resp_valid   (resp_valid),
    .tpg_complete (tpg_complete),
    .signature    (signature),
    .vec_cnt      (vec_cnt),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout)
  );

  typedef struct {
    logic [23:0] vecs;
    int          n;
    bit          sep;
    logic [3:0]  exp_sig;
    bit          exp_pass;
  } vec_t;

  vec_t tbl[6];

  // Signature model: multiply by two modulo 16, fold the overflow back as taps 0x3, add response bits.
  function automatic logic [3:0] model_step(input logic [3:0] s, input logic [1:0] r);
    int t;
    t = int'(s) * 2;
    if (t >= 16) t = (t - 16) ^ 3;
    return 4'(t ^ int'(r));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_done", 32'(done), 0);
    chk("start_pass", 32'(pass), 0);
    chk("start_fail", 32'(fail), 0);
    chk("start_sig", 32'(signature), 0);
    chk("start_cnt", 32'(vec_cnt), 0);
    chk("start_tmo", 32'(timeout), 0);
  endtask

  // One full analysis; optional idle gaps and stray start pulses that must be ignored.
  task automatic run_seq(input logic [23:0] vecs, input int n, input bit sep,
                         input bit gaps, input bit noise, output logic [3:0] m_out);
    logic [3:0] m;
    int cnt;
    m = 4'h0;
    cnt = 0;
    do_start();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        resp_valid = 1'b0;
        tpg_complete = 1'b0;
        resp_in = 2'($urandom);
        start = noise ? 1'($urandom) : 1'b0;
        tick();
        chk("gap_sig", 32'(signature), 32'(m));
      end
      resp_in = vecs[2*i +: 2];
      resp_valid = 1'b1;
      tpg_complete = (i == n - 1) && !sep;
      start = noise ? 1'($urandom) : 1'b0;
      tick();
      m = model_step(m, vecs[2*i +: 2]);
      cnt++;
      chk("step_sig", 32'(signature), 32'(m));
      chk("step_cnt", 32'(vec_cnt), 32'(cnt));
    end
    if (sep) begin
      resp_valid = 1'b0;
      tpg_complete = 1'b1;
      resp_in = 2'b11;
      start = noise ? 1'($urandom) : 1'b0;
      tick();
    end
    resp_valid = 1'b0;
    tpg_complete = 1'b0;
    start = noise;
    chk("cmp_busy", 32'(busy), 1);
    chk("cmp_done", 32'(done), 0);
    chk("cmp_sig", 32'(signature), 32'(m));
    tick();
    start = 1'b0;
    chk("done_done", 32'(done), 1);
    chk("done_pass", 32'(pass), 32'(m == GOLD));
    chk("done_fail", 32'(fail), 32'(m != GOLD));
    chk("done_busy", 32'(busy), 0);
    chk("done_cnt", 32'(vec_cnt), 32'(cnt));
    chk("done_tmo", 32'(timeout), 0);
    resp_valid = 1'b1;
    resp_in = 2'b01;
    tick();
    resp_valid = 1'b0;
    chk("hold_done", 32'(done), 1);
    chk("hold_sig", 32'(signature), 32'(m));
    chk("hold_pf", 32'({pass, fail}), 32'({m == GOLD, m != GOLD}));
    m_out = m;
  endtask

  initial begin
    logic [3:0] msig;
    logic [3:0] m;

    tbl[0] = '{vecs: 24'h67, n: 4, sep: 1'b0, exp_sig: 4'hA, exp_pass: 1'b1};
    tbl[1] = '{vecs: 24'h63, n: 4, sep: 1'b0, exp_sig: 4'hE, exp_pass: 1'b0};
    tbl[2] = '{vecs: 24'h07, n: 2, sep: 1'b1, exp_sig: 4'h7, exp_pass: 1'b0};
    tbl[3] = '{vecs: 24'h00, n: 3, sep: 1'b0, exp_sig: 4'h0, exp_pass: 1'b0};
    tbl[4] = '{vecs: 24'h02, n: 1, sep: 1'b0, exp_sig: 4'h2, exp_pass: 1'b0};
    tbl[5] = '{vecs: 24'hFF, n: 4, sep: 1'b0, exp_sig: 4'h2, exp_pass: 1'b0};

    // Power-on reset
    tick();
    tick();
    chk("rst_sig", 32'(signature), 0);
    chk("rst_flags", 32'({busy, done, pass, fail, timeout}), 0);
    reset = 1'b0;
    tick();

    // Asynchronous reset in the middle of COMPRESS
    do_start();
    resp_valid = 1'b1;
    resp_in = 2'b11;
    tick();
    resp_in = 2'b01;
    tick();
    resp_valid = 1'b0;
    chk("pre_rst_cnt", 32'(vec_cnt), 2);
    #2 reset = 1'b1;
    #1;
    chk("arst_sig", 32'(signature), 0);
    chk("arst_cnt", 32'(vec_cnt), 0);
    chk("arst_flags", 32'({busy, done, pass, fail}), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 0);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      run_seq(tbl[i].vecs, tbl[i].n, tbl[i].sep, 1'b0, 1'b0, msig);
      chk($sformatf("tbl%0d_sig", i), 32'(signature), 32'(tbl[i].exp_sig));
      chk($sformatf("tbl%0d_pass", i), 32'(pass), 32'(tbl[i].exp_pass));
      chk($sformatf("tbl%0d_fail", i), 32'(fail), 32'(!tbl[i].exp_pass));
    end

    // Start in DONE after a no-valid completion reloads the seed and clears flags
    run_seq(24'h07, 2, 1'b1, 1'b0, 1'b0, msig);
    chk("nv_sig", 32'(signature), 32'h7);
    do_start();
    tpg_complete = 1'b1;
    tick();
    tpg_complete = 1'b0;
    tick();
    chk("empty_done", 32'({done, pass, fail}), 32'b101);
    chk("empty_cnt", 32'(vec_cnt), 0);

    // Stray start pulses during COMPRESS and COMPARE
    run_seq(24'h67, 4, 1'b0, 1'b0, 1'b1, msig);
    chk("noise_pass", 32'({pass, fail}), 32'b10);

`ifdef BIST_ORA_TIMEOUT_EN
    // Watchdog expiry
    do_start();
    repeat (15) tick();
    chk("tmo_pre_busy", 32'(busy), 1);
    chk("tmo_pre_flag", 32'(timeout), 0);
    tick();
    chk("tmo_flags", 32'({done, pass, fail, timeout}), 32'b1011);
    chk("tmo_busy", 32'(busy), 0);
    // Completion in the final count cycle wins
    do_start();
    repeat (15) tick();
    tpg_complete = 1'b1;
    tick();
    tpg_complete = 1'b0;
    chk("tmo_race_busy", 32'(busy), 1);
    chk("tmo_race_tmo", 32'(timeout), 0);
    tick();
    chk("tmo_race_flags", 32'({done, pass, fail, timeout}), 32'b1010);
`else
    // No watchdog: waits indefinitely
    do_start();
    repeat (100) tick();
    chk("wait_busy", 32'(busy), 1);
    chk("wait_flags", 32'({done, timeout}), 0);
    tpg_complete = 1'b1;
    tick();
    tpg_complete = 1'b0;
    tick();
    chk("wait_end", 32'({done, fail}), 32'b11);

    // Vector counter saturation; signature keeps moving
    do_start();
    m = 4'h0;
    for (int i = 0; i < 260; i++) begin
      resp_in = 2'($urandom);
      resp_valid = 1'b1;
      m = model_step(m, resp_in);
      tick();
    end
    resp_valid = 1'b0;
    chk("sat_cnt", 32'(vec_cnt), 255);
    chk("sat_sig", 32'(signature), 32'(m));
    tpg_complete = 1'b1;
    tick();
    tpg_complete = 1'b0;
    tick();
    chk("sat_pass", 32'({done, pass, fail}), 32'({1'b1, m == GOLD, m != GOLD}));
`endif

    // Randomized analyses
    for (int k = 0; k < 20; k++) begin
      logic [23:0] rv;
      rv = 24'($urandom);
      run_seq(rv, int'($urandom_range(1, 6)), 1'($urandom), 1'b1, 1'b1, msig);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
